gmii_rx_rate_adapt: RTL and testbench

- Receive-side successor to the RGMII-to-GMII bridge.
- Sits on the GMII receive output, in the `gmii_rx_clk` domain, and normalises 10/100/1000 Mb/s traffic into one byte stream:
  - 1000 mode: one byte per clock.
  - 10/100 mode: one nibble per clock on `gmii_rxd[3:0]`.
- Strips preamble/SFD and marks frame boundaries.
- Flags odd-nibble, missing-SFD and over-long-preamble frames and keeps saturating frame/error counters for the UDP/camera pipeline.

---
 rtl/gmii_rx_rate_adapt.sv | 237 +++++++++++++++++++++++
 tb/tb_gmii_rx_rate_adapt.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_rate_adapt.sv
// GMII receive rate adapter: folds 10/100 nibble and 1000 byte traffic into one
// byte stream, strips preamble/SFD, marks frame boundaries and counts frames.
//
// state  | meaning
// DROP   | discard until rx_dv is low
// IDLE   | between frames, speed is latched on the first dv sample
// PRE    | hunting for SFD, counting preamble
// DATA   | assembling bytes into the hold register
module gmii_rx_rate_adapt #(
    parameter int CNT_W        = 16,
    parameter int ALIGN_ON_SFD = 1,
    parameter int PRE_MAX      = 15
) (
    input  logic             gmii_rx_clk,
    input  logic             sys_rst,
    input  logic [1:0]       speed_mode,
    input  logic             gmii_rx_dv,
    input  logic [7:0]       gmii_rxd,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic             sof,
    output logic             eof,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int PRE_W = $clog2(PRE_MAX + 1);

    localparam logic [1:0] S_DROP = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_PRE  = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    logic             dv_q, gig_q;
    logic [7:0]       rxd_q;
    logic [1:0]       state_q, state_d;
    logic             nib_q, nib_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             pre_half_q, pre_half_d;
    logic             prev5_q, prev5_d;
    logic             phase_q, phase_d;
    logic [3:0]       lo_q, lo_d;
    logic [7:0]       hold_q, hold_d;
    logic             held_q, held_d;
    logic             first_q, first_d;
    logic             bv_q, bv_d, sof_q, sof_d, eof_q, eof_d, ferr_q, ferr_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d, ecnt_q, ecnt_d;

    logic       mode_nib, do_pre, do_data, done, emit, good, bad;
    logic [7:0] new_byte;

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        pre_cnt_d  = pre_cnt_q;
        pre_half_d = pre_half_q;
        prev5_d    = prev5_q;
        phase_d    = phase_q;
        lo_d       = lo_q;
        hold_d     = hold_q;
        held_d     = held_q;
        first_d    = first_q;
        bv_d       = 1'b0;
        data_d     = data_q;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        ferr_d     = 1'b0;
        fcnt_d     = fcnt_q;
        ecnt_d     = ecnt_q;
        do_pre     = 1'b0;
        do_data    = 1'b0;
        done       = 1'b0;
        emit       = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        new_byte   = 8'h00;
        // In IDLE the first sample already uses the speed being latched now
        mode_nib   = (state_q == S_IDLE) ? !gig_q : nib_q;

        case (state_q)
            S_DROP: begin
                if (!dv_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                nib_d = !gig_q;
                if (dv_q) begin
                    if (ALIGN_ON_SFD != 0) do_pre = 1'b1;
                    else                   do_data = 1'b1;
                end
            end
            S_PRE: begin
                if (dv_q) begin
                    do_pre = 1'b1;
                end else begin
                    ferr_d  = 1'b1;
                    bad     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (dv_q) begin
                    do_data = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    if (held_q) begin
                        emit  = 1'b1;
                        eof_d = 1'b1;
                        if (phase_q) begin
                            ferr_d = 1'b1;
                            bad    = 1'b1;
                        end else begin
                            good = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                        bad    = 1'b1;
                    end
                end
            end
        endcase

        if (do_pre) begin
            state_d = S_PRE;
            if (mode_nib ? (prev5_q && rxd_q[3:0] == 4'hD) : (rxd_q == 8'hD5)) begin
                state_d = S_DATA;
                phase_d = 1'b0;
            end else begin
                prev5_d    = (rxd_q[3:0] == 4'h5);
                pre_half_d = mode_nib ? !pre_half_q : 1'b0;
                if (!mode_nib || pre_half_q) begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    if (pre_cnt_d == PRE_W'(PRE_MAX)) begin
                        ferr_d  = 1'b1;
                        bad     = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
        end

        if (do_data) begin
            state_d = S_DATA;
            if (!mode_nib) begin
                done     = 1'b1;
                new_byte = rxd_q;
            end else if (!phase_q) begin
                lo_d    = rxd_q[3:0];
                phase_d = 1'b1;
            end else begin
                done     = 1'b1;
                new_byte = {rxd_q[3:0], lo_q};
                phase_d  = 1'b0;
            end
            if (done) begin
                emit   = held_q;
                hold_d = new_byte;
                held_d = 1'b1;
            end
        end

        if (emit) begin
            bv_d    = 1'b1;
            data_d  = hold_q;
            sof_d   = first_q;
            first_d = 1'b0;
        end

        // Leaving the frame: start the next one from a clean context
        if (state_d != S_PRE && state_d != S_DATA) begin
            pre_cnt_d  = '0;
            pre_half_d = 1'b0;
            prev5_d    = 1'b0;
            phase_d    = 1'b0;
            held_d     = 1'b0;
            first_d    = 1'b1;
        end

        if (good && fcnt_q != {CNT_W{1'b1}}) fcnt_d = fcnt_q + CNT_W'(1);
        if (bad && ecnt_q != {CNT_W{1'b1}})  ecnt_d = ecnt_q + CNT_W'(1);
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            // dv_q comes up high so DROP cannot see a false gap in a frame still on the wire
            dv_q       <= 1'b1;
            gig_q      <= 1'b0;
            rxd_q      <= 8'h00;
            state_q    <= S_DROP;
            nib_q      <= 1'b0;
            pre_cnt_q  <= '0;
            pre_half_q <= 1'b0;
            prev5_q    <= 1'b0;
            phase_q    <= 1'b0;
            lo_q       <= 4'h0;
            hold_q     <= 8'h00;
            held_q     <= 1'b0;
            first_q    <= 1'b1;
            bv_q       <= 1'b0;
            data_q     <= 8'h00;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            ferr_q     <= 1'b0;
            fcnt_q     <= '0;
            ecnt_q     <= '0;
        end else begin
            dv_q       <= gmii_rx_dv;
            gig_q      <= (speed_mode == 2'b10) || (speed_mode == 2'b11);
            rxd_q      <= gmii_rxd;
            state_q    <= state_d;
            nib_q      <= nib_d;
            pre_cnt_q  <= pre_cnt_d;
            pre_half_q <= pre_half_d;
            prev5_q    <= prev5_d;
            phase_q    <= phase_d;
            lo_q       <= lo_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
            first_q    <= first_d;
            bv_q       <= bv_d;
            data_q     <= data_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            ferr_q     <= ferr_d;
            fcnt_q     <= fcnt_d;
            ecnt_q     <= ecnt_d;
        end
    end

    assign byte_valid = bv_q;
    assign byte_data  = data_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign frame_err  = ferr_q;
    assign frame_cnt  = fcnt_q;
    assign err_cnt    = ecnt_q;
endmodule

// File: tb/tb_gmii_rx_rate_adapt.sv
// Bench for gmii_rx_rate_adapt: directed frames plus random frames scored against
// a per-frame reference model; a second CNT_W=2 instance exercises saturation.
module tb_gmii_rx_rate_adapt;
    localparam int PRE_MAX = 15;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [1:0]  speed_mode = 2'b10;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        byte_valid, sof, eof, frame_err;
    logic [7:0]  byte_data;
    logic [15:0] frame_cnt, err_cnt;
    logic        s_bv, s_sof, s_eof, s_ferr;
    logic [7:0]  s_data;
    logic [1:0]  s_fcnt, s_ecnt;

    gmii_rx_rate_adapt #(.CNT_W(16), .ALIGN_ON_SFD(1), .PRE_MAX(PRE_MAX)) dut (
        .gmii_rx_clk(clk), .sys_rst(sys_rst), .speed_mode(speed_mode),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .byte_valid(byte_valid), .byte_data(byte_data), .sof(sof), .eof(eof),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt));

    gmii_rx_rate_adapt #(.CNT_W(2), .ALIGN_ON_SFD(1), .PRE_MAX(PRE_MAX)) dut_sat (
        .gmii_rx_clk(clk), .sys_rst(sys_rst), .speed_mode(speed_mode),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .byte_valid(s_bv), .byte_data(s_data), .sof(s_sof), .eof(s_eof),
        .frame_err(s_ferr), .frame_cnt(s_fcnt), .err_cnt(s_ecnt));

    always #5 clk = ~clk;

    typedef struct {
        logic       bv;
        logic       sof;
        logic       eof;
        logic       err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         cap_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;
    int         m_good = 0;
    int         m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (byte_valid || sof || eof || frame_err)
            got_q.push_back('{byte_valid, sof, eof, frame_err, byte_data, cyc});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clip(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [11:0] pack_ev(input ev_t e);
        return {e.bv, e.sof, e.eof, e.err, (e.bv ? e.data : 8'h00)};
    endfunction

    // Reference: decode one frame's units into the output events it must produce
    task automatic model_frame(input logic nib);
        int   i, ign, ndat, nby;
        logic found, abort, odd;
        logic [7:0] b;
        i = 0; ign = 0; found = 1'b0; abort = 1'b0;
        while (i < stim_q.size() && !found && !abort) begin
            if (nib ? (i > 0 && stim_q[i][3:0] == 4'hD && stim_q[i-1][3:0] == 4'h5)
                    : (stim_q[i] == 8'hD5))
                found = 1'b1;
            else begin
                ign++;
                if (ign == (nib ? 2 * PRE_MAX : PRE_MAX)) abort = 1'b1;
            end
            i++;
        end
        if (!found) begin
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0});
            m_err++;
            return;
        end
        ndat = stim_q.size() - i;
        nby  = nib ? ndat / 2 : ndat;
        odd  = nib && (ndat % 2 == 1);
        if (nby == 0) begin
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0});
            m_err++;
            return;
        end
        for (int k = 0; k < nby; k++) begin
            b = nib ? {stim_q[i + 2*k + 1][3:0], stim_q[i + 2*k][3:0]} : stim_q[i + k];
            exp_q.push_back('{1'b1, (k == 0), (k == nby - 1), (k == nby - 1) && odd, b, 0});
        end
        if (odd) m_err++;
        else     m_good++;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
    endtask

    task automatic send_frame(input logic [1:0] spd, input int tog_at, input int gap);
        logic nib;
        nib = !spd[1];
        model_frame(nib);
        speed_mode = spd;
        cap_q.delete();
        for (int i = 0; i < stim_q.size(); i++) begin
            @(posedge clk);
            #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = nib ? {4'($urandom), stim_q[i][3:0]} : stim_q[i];
            if (i == tog_at) speed_mode = ~speed_mode;
            cap_q.push_back(cyc + 1);
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 8'($urandom));
    endtask

    task automatic compare_events();
        ev_t g, e;
        check("ev_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check("ev", pack_ev(g), pack_ev(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counters();
        check("frame_cnt", frame_cnt, clip(m_good, 65535));
        check("err_cnt", err_cnt, clip(m_err, 65535));
        check("sat_frame_cnt", s_fcnt, clip(m_good, 3));
        check("sat_err_cnt", s_ecnt, clip(m_err, 3));
    endtask

    task automatic drain();
        repeat (6) drive(1'b0, 8'h00);
        compare_events();
        check_counters();
    endtask

    task automatic push_nib_byte(input logic [7:0] b);
        stim_q.push_back({4'h0, b[3:0]});
        stim_q.push_back({4'h0, b[7:4]});
    endtask

    task automatic build_gig_frame(input int npre, input int ndata);
        stim_q.delete();
        repeat (npre) stim_q.push_back(8'h55);
        stim_q.push_back(8'hD5);
        for (int b = 1; b <= ndata; b++) stim_q.push_back(8'(b));
    endtask

    task automatic build_random(input logic nib);
        int kind, k, dl;
        stim_q.delete();
        kind = $urandom_range(0, 7);
        if (kind == 6) begin
            k = nib ? $urandom_range(2 * PRE_MAX, 2 * PRE_MAX + 6) : $urandom_range(PRE_MAX, PRE_MAX + 5);
            repeat (k) stim_q.push_back(nib ? 8'h05 : 8'h55);
        end else if (kind == 7) begin
            k = $urandom_range(1, 6);
            repeat (k) stim_q.push_back(nib ? 8'h05 : 8'h55);
        end else begin
            k = nib ? $urandom_range(1, 2 * PRE_MAX - 1) : $urandom_range(0, PRE_MAX - 1);
            repeat (k) stim_q.push_back(nib ? 8'h05 : 8'h55);
            stim_q.push_back(nib ? 8'h0D : 8'hD5);
            dl = nib ? $urandom_range(0, 24) : $urandom_range(0, 20);
            repeat (dl) stim_q.push_back(nib ? 8'($urandom_range(0, 15)) : 8'($urandom));
        end
    endtask

    initial begin
        int spd, tog;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_sof_eof", {sof, eof}, 2'b00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_counters", {frame_cnt, err_cnt}, 32'h0);
        sys_rst = 1'b0;
        repeat (3) drive(1'b0, 8'h00);

        // 1000 mode, 64 bytes, latency checked per byte
        build_gig_frame(7, 64);
        send_frame(2'b10, -1, 4);
        repeat (4) drive(1'b0, 8'h00);
        for (int k = 0; k < 64; k++)
            if (k < got_q.size() && 8 + k < cap_q.size())
                check("latency", got_q[k].cyc - cap_q[8 + k], 2);
        compare_events();
        check_counters();

        // 100 mode, 52 bytes
        stim_q.delete();
        repeat (15) stim_q.push_back(8'h05);
        stim_q.push_back(8'h0D);
        for (int b = 1; b <= 8'h34; b++) push_nib_byte(8'(b));
        send_frame(2'b01, -1, 3);
        drain();

        // 10 mode, odd trailing nibble
        stim_q.delete();
        repeat (15) stim_q.push_back(8'h05);
        stim_q.push_back(8'h0D);
        for (int b = 0; b < 5; b++) push_nib_byte(8'hA1 + 8'(b));
        stim_q.push_back(8'h07);
        send_frame(2'b00, -1, 3);
        drain();

        // Over-long preamble in 1000 mode
        stim_q.delete();
        repeat (20) stim_q.push_back(8'h55);
        send_frame(2'b11, -1, 3);
        drain();

        // Speed switched to 1000 mid-frame; frame stays in nibble mode
        stim_q.delete();
        repeat (15) stim_q.push_back(8'h05);
        stim_q.push_back(8'h0D);
        for (int b = 0; b < 8; b++) push_nib_byte(8'h3C ^ 8'(b));
        send_frame(2'b00, 20, 1);
        build_gig_frame(3, 5);
        send_frame(2'b10, -1, 1);
        drain();

        // Reset pulse at byte 10 of a 64-byte frame, dv held high
        build_gig_frame(7, 64);
        speed_mode = 2'b10;
        for (int i = 0; i < stim_q.size(); i++) begin
            @(posedge clk);
            #1;
            sys_rst    = (i == 17);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = stim_q[i];
            if (i == 18) begin
                check("mid_rst_outputs", {byte_valid, sof, eof, frame_err, byte_data}, 12'h000);
                check("mid_rst_counters", {frame_cnt, err_cnt, s_fcnt, s_ecnt}, 36'h0);
                got_q.delete();
                m_good = 0;
                m_err  = 0;
            end
        end
        repeat (3) drive(1'b0, 8'h00);
        drain();
        build_gig_frame(7, 12);
        send_frame(2'b10, -1, 2);
        drain();

        // Random frames at random speeds with occasional mid-frame speed flips
        for (int f = 0; f < 48; f++) begin
            spd = $urandom_range(0, 3);
            build_random(spd < 2);
            tog = (stim_q.size() > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, stim_q.size() - 1) : -1;
            send_frame(2'(spd), tog, $urandom_range(1, 3));
            if (f % 8 == 7) drain();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
